qbox_anim_renderer: RTL and testbench

QBOX_ANIM_RENDERER -- requirements
Module: qbox_anim_renderer

---
 rtl/color_pkg.sv | 84 ++++++++
 rtl/qbox_anim_fsm.sv | 70 +++++++
 rtl/qbox_anim_renderer.sv | 111 +++++++++++
 tb/tb_qbox_anim_renderer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the question-box renderer.
//   rgb_t        : 24-bit packed pixel colour (r, g, b)
//   colour names : BLACK, WHITE, BROWN, BROWN_DARK, YELLOW_BRIGHT/MID/DARK
//   qbox_state_t : per-box animation state
//   glyph_row    : 16x16 question-mark bitmap, column 0 at bit 15
//   box_color    : colour of one 16x16 cell for a given state and shimmer phase
package color_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK         = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t WHITE         = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BROWN         = '{r: 8'h88, g: 8'h44, b: 8'h00};
    localparam rgb_t BROWN_DARK    = '{r: 8'h44, g: 8'h22, b: 8'h00};
    localparam rgb_t YELLOW_BRIGHT = '{r: 8'hFF, g: 8'hE0, b: 8'h00};
    localparam rgb_t YELLOW_MID    = '{r: 8'hD0, g: 8'hA0, b: 8'h00};
    localparam rgb_t YELLOW_DARK   = '{r: 8'h90, g: 8'h60, b: 8'h00};

    typedef enum logic [1:0] {
        IDLE,
        BUMP_UP,
        BUMP_DOWN,
        USED
    } qbox_state_t;

    // Glyph stays inside cells 2..13 so it never touches the two outer rings.
    function automatic logic [15:0] glyph_row(input logic [3:0] row);
        logic [15:0] bits;
        case (row)
            4'd3:    bits = 16'h07C0;
            4'd4:    bits = 16'h0C60;
            4'd5:    bits = 16'h0060;
            4'd6:    bits = 16'h00C0;
            4'd7:    bits = 16'h0180;
            4'd8:    bits = 16'h0300;
            4'd9:    bits = 16'h0300;
            4'd11:   bits = 16'h0300;
            4'd12:   bits = 16'h0300;
            default: bits = 16'h0000;
        endcase
        return bits;
    endfunction

    function automatic rgb_t shimmer_color(input logic [1:0] phase);
        rgb_t c;
        case (phase)
            2'd0:    c = YELLOW_BRIGHT;
            2'd2:    c = YELLOW_DARK;
            default: c = YELLOW_MID;
        endcase
        return c;
    endfunction

    function automatic rgb_t box_color(input qbox_state_t st,
                                       input logic [3:0]  cx,
                                       input logic [3:0]  cy,
                                       input logic [1:0]  phase);
        logic [15:0] row_bits;
        logic        glyph;
        logic        ring0;
        logic        ring1;
        rgb_t        c;
        row_bits = glyph_row(cy);
        glyph    = row_bits[4'd15 - cx];
        ring0    = (cx == 4'd0) || (cx == 4'd15) || (cy == 4'd0) || (cy == 4'd15);
        ring1    = (cx == 4'd1) || (cx == 4'd14) || (cy == 4'd1) || (cy == 4'd14);
        if (st == USED)
            c = ring0 ? BROWN : BROWN_DARK;
        else if (glyph)
            c = WHITE;
        else if (ring0)
            c = BROWN;
        else if (ring1)
            c = YELLOW_DARK;
        else
            c = shimmer_color(phase);
        return c;
    endfunction

endpackage

// File: rtl/qbox_anim_fsm.sv
// Per-box bump animation: IDLE -> BUMP_UP -> BUMP_DOWN -> USED -> IDLE.
//   clk, reset  : system clock, asynchronous active-high reset
//   frame_tick  : one pulse per frame; advances the bump offset
//   hit, rearm  : start the bump from IDLE / return from USED to IDLE
//   state       : current animation state (registered)
//   offset      : upward pixel offset of the box, 0..BUMP_PX (registered)
module qbox_anim_fsm
    import color_pkg::*;
#(
    parameter int unsigned BUMP_PX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        rearm,
    output qbox_state_t state,
    output logic [3:0]  offset
);

    qbox_state_t state_d;
    logic [3:0]  offset_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            offset <= '0;
        end else begin
            state  <= state_d;
            offset <= offset_d;
        end
    end

    always_comb begin
        state_d  = state;
        offset_d = offset;
        case (state)
            IDLE: begin
                // a frame_tick in the same cycle as hit does not count
                if (hit) begin
                    state_d  = BUMP_UP;
                    offset_d = '0;
                end
            end
            BUMP_UP: begin
                if (frame_tick) begin
                    offset_d = offset + 4'd1;
                    if (offset_d == 4'(BUMP_PX))
                        state_d = BUMP_DOWN;
                end
            end
            BUMP_DOWN: begin
                if (frame_tick) begin
                    offset_d = offset - 4'd1;
                    if (offset_d == '0)
                        state_d = USED;
                end
            end
            USED: begin
                if (rearm)
                    state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                offset_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/qbox_anim_renderer.sv
// Renders NUM_BOXES animated question boxes into the pixel stream.
//   clk, reset    : system clock, asynchronous active-high reset
//   frame_tick    : one pulse per frame (vblank start)
//   x, y          : current scan coordinate
//   box_x, box_y  : packed box centres, box i at [10i+9:10i]
//   hit, rearm    : per-box one-cycle animation requests
//   used          : per-box flag, high while the box is in USED
//   color, enable : registered pixel colour / in-any-box flag, 1 clk after x,y
module qbox_anim_renderer
    import color_pkg::*;
#(
    parameter int unsigned NUM_BOXES      = 4,
    parameter int unsigned SCALE          = 2,
    parameter int unsigned BUMP_PX        = 4,
    parameter int unsigned SHIMMER_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic [10*NUM_BOXES-1:0] box_x,
    input  logic [10*NUM_BOXES-1:0] box_y,
    input  logic [NUM_BOXES-1:0]    hit,
    input  logic [NUM_BOXES-1:0]    rearm,
    output logic [NUM_BOXES-1:0]    used,
    output rgb_t                    color,
    output logic                    enable
);

    localparam int unsigned HALF  = 8 * SCALE;
    localparam int unsigned EDGE  = 16 * SCALE;
    localparam int unsigned SHIFT = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int unsigned SW    = (SHIMMER_FRAMES > 1) ? $clog2(SHIMMER_FRAMES) : 1;

    logic [SW-1:0] shim_cnt;
    logic [1:0]    shim_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shim_cnt   <= '0;
            shim_phase <= '0;
        end else if (frame_tick) begin
            if (shim_cnt == SW'(SHIMMER_FRAMES - 1)) begin
                shim_cnt   <= '0;
                shim_phase <= shim_phase + 2'd1;
            end else begin
                shim_cnt <= shim_cnt + 1'b1;
            end
        end
    end

    qbox_state_t box_state [NUM_BOXES];
    logic [3:0]  box_off   [NUM_BOXES];
    logic [11:0] rel_x     [NUM_BOXES];
    logic [11:0] rel_y     [NUM_BOXES];
    logic [3:0]  cell_x    [NUM_BOXES];
    logic [3:0]  cell_y    [NUM_BOXES];
    logic        in_box    [NUM_BOXES];

    for (genvar g = 0; g < NUM_BOXES; g++) begin : g_box
        qbox_anim_fsm #(
            .BUMP_PX(BUMP_PX)
        ) u_fsm (
            .clk       (clk),
            .reset     (reset),
            .frame_tick(frame_tick),
            .hit       (hit[g]),
            .rearm     (rearm[g]),
            .state     (box_state[g]),
            .offset    (box_off[g])
        );

        assign used[g] = (box_state[g] == USED);

        // y - (box_y - offset) rewritten as y - box_y + offset
        assign rel_x[g] = {2'b00, x} - {2'b00, box_x[10*g +: 10]} + 12'(HALF);
        assign rel_y[g] = {2'b00, y} - {2'b00, box_y[10*g +: 10]}
                        + {8'h00, box_off[g]} + 12'(HALF);
        // negative rel values are >= 2048 unsigned, so one compare clips both sides
        assign in_box[g] = (rel_x[g] < 12'(EDGE)) && (rel_y[g] < 12'(EDGE));
        assign cell_x[g] = 4'(rel_x[g] >> SHIFT);
        assign cell_y[g] = 4'(rel_y[g] >> SHIFT);
    end

    rgb_t pix_color;
    logic pix_en;

    // walk from the highest index down so the lowest overlapping box wins
    always_comb begin
        pix_en    = 1'b0;
        pix_color = BLACK;
        for (int unsigned k = NUM_BOXES; k > 0; k--) begin
            if (in_box[k-1]) begin
                pix_en    = 1'b1;
                pix_color = box_color(box_state[k-1], cell_x[k-1], cell_y[k-1], shim_phase);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color  <= BLACK;
            enable <= 1'b0;
        end else begin
            color  <= pix_color;
            enable <= pix_en;
        end
    end

endmodule

// File: tb/tb_qbox_anim_renderer.sv
// Self-checking bench for qbox_anim_renderer: directed scenarios followed by
// randomized traffic, compared against a frame-count based reference model.
module tb_qbox_anim_renderer;
    import color_pkg::*;

    localparam int NB = 4;
    localparam int SC = 2;
    localparam int BP = 4;
    localparam int SF = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_tick;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [10*NB-1:0] box_x;
    logic [10*NB-1:0] box_y;
    logic [NB-1:0]    hit;
    logic [NB-1:0]    rearm;
    logic [NB-1:0]    used;
    rgb_t             color;
    logic             enable;

    always #5 clk = ~clk;

    qbox_anim_renderer #(
        .NUM_BOXES     (NB),
        .SCALE         (SC),
        .BUMP_PX       (BP),
        .SHIMMER_FRAMES(SF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .x         (x),
        .y         (y),
        .box_x     (box_x),
        .box_y     (box_y),
        .hit       (hit),
        .rearm     (rearm),
        .used      (used),
        .color     (color),
        .enable    (enable)
    );

    int checks = 0;
    int errors = 0;

    // Model: box centres, and per box the number of frame ticks since the hit
    // (-1 = idle, 2*BP = used). Offset rises then falls with that count.
    int bx [NB];
    int by [NB];
    int mk [NB];
    int mframes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic place();
        for (int i = 0; i < NB; i++) begin
            box_x[10*i +: 10] = 10'(bx[i]);
            box_y[10*i +: 10] = 10'(by[i]);
        end
    endtask

    function automatic int m_off(int i);
        if (mk[i] < 0) return 0;
        return (mk[i] <= BP) ? mk[i] : 2*BP - mk[i];
    endfunction

    function automatic logic [24:0] ref_pixel(int px, int py);
        rgb_t        shim [4];
        logic [15:0] gr;
        int          rx, ry, cx, cy, d;
        shim = '{YELLOW_BRIGHT, YELLOW_MID, YELLOW_DARK, YELLOW_MID};
        for (int i = 0; i < NB; i++) begin
            rx = px - bx[i] + 8*SC;
            ry = py - (by[i] - m_off(i)) + 8*SC;
            if (rx >= 0 && rx < 16*SC && ry >= 0 && ry < 16*SC) begin
                cx = rx / SC;
                cy = ry / SC;
                d  = cx;
                if (15 - cx < d) d = 15 - cx;
                if (cy < d)      d = cy;
                if (15 - cy < d) d = 15 - cy;
                gr = glyph_row(4'(cy));
                if (mk[i] == 2*BP)     return {1'b1, (d == 0) ? BROWN : BROWN_DARK};
                if (gr[15 - cx])       return {1'b1, WHITE};
                if (d == 0)            return {1'b1, BROWN};
                if (d == 1)            return {1'b1, YELLOW_DARK};
                return {1'b1, shim[(mframes / SF) % 4]};
            end
        end
        return {1'b0, BLACK};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mk[i] = -1;
        mframes = 0;
    endtask

    task automatic model_update(input logic tk, input logic [NB-1:0] h, input logic [NB-1:0] r);
        for (int i = 0; i < NB; i++) begin
            if (mk[i] < 0) begin
                if (h[i]) mk[i] = 0;
            end else if (mk[i] < 2*BP) begin
                if (tk) mk[i]++;
            end else if (r[i]) begin
                mk[i] = -1;
            end
        end
        if (tk) mframes++;
    endtask

    // One clock: drive at negedge, check the registered result 1 unit after posedge.
    task automatic step(input int px, input int py, input logic tk,
                        input logic [NB-1:0] h, input logic [NB-1:0] r, input string tag);
        logic [24:0]   e;
        logic [NB-1:0] eu;
        x = 10'(px); y = 10'(py); frame_tick = tk; hit = h; rearm = r;
        place();
        e = ref_pixel(px, py);
        @(posedge clk);
        model_update(tk, h, r);
        #1;
        for (int i = 0; i < NB; i++) eu[i] = (mk[i] == 2*BP);
        check({tag, " enable"}, 32'(enable), 32'(e[24]));
        check({tag, " color"},  {8'h00, color}, {8'h00, e[23:0]});
        check({tag, " used"},   32'(used), 32'(eu));
        @(negedge clk);
        frame_tick = 1'b0; hit = '0; rearm = '0;
    endtask

    initial begin
        int e;
        reset = 1'b1; frame_tick = 1'b0; hit = '0; rearm = '0; x = '0; y = '0;
        bx = '{100, 300, 500, 900};
        by = '{100, 60, 400, 700};
        place();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset enable", 32'(enable), 32'd0);
        check("reset color",  {8'h00, color}, {8'h00, BLACK});
        check("reset used",   32'(used), 32'd0);
        reset = 1'b0;

        // idle box centre cell shows shimmer phase 0
        step(100, 100, 1'b0, '0, '0, "idle_centre");
        check("idle_centre bright", {8'h00, color}, {8'h00, YELLOW_BRIGHT});

        // horizontal scan across a box centred at (16,16)
        bx[0] = 16; by[0] = 16;
        for (int i = 0; i <= 32; i++) begin
            step(i, 16, 1'b0, '0, '0, "row_scan");
            check("row_scan span", 32'(enable), (i <= 31) ? 32'd1 : 32'd0);
            if (i <= 1 || i == 30 || i == 31)
                check("row_scan ring0", {8'h00, color}, {8'h00, BROWN});
            if (i == 32)
                check("row_scan outside", {8'h00, color}, {8'h00, BLACK});
        end
        // box partly off the left/top edge: clipped, never wrapped
        bx[0] = 8; by[0] = 8;
        step(0, 8, 1'b0, '0, '0, "clip_left");
        check("clip_left visible", 32'(enable), 32'd1);
        step(1023, 8, 1'b0, '0, '0, "clip_nowrap_x");
        check("clip_nowrap_x", 32'(enable), 32'd0);
        step(8, 1023, 1'b0, '0, '0, "clip_nowrap_y");
        check("clip_nowrap_y", 32'(enable), 32'd0);
        bx[0] = 100; by[0] = 100;

        // full bump: top edge row tracks the offset 1,2,3,4,3,2,1,0
        step(100, 100, 1'b0, 4'b0001, '0, "hit0");
        for (int t = 1; t <= 2*BP; t++) begin
            step(100, 100, 1'b1, '0, '0, "bump_tick");
            e = (t <= BP) ? t : 2*BP - t;
            step(100, 100 - e - 16, 1'b0, '0, '0, "bump_top");
            check("bump_top edge", {8'h00, color}, {8'h00, BROWN});
            step(100, 100 - e - 17, 1'b0, '0, '0, "bump_above");
            check("bump_above clear", 32'(enable), 32'd0);
        end
        check("bump used0", 32'(used[0]), 32'd1);
        step(98, 98, 1'b0, '0, '0, "used_glyph");
        check("used no glyph", {8'h00, color}, {8'h00, BROWN_DARK});

        // rearm from USED, then hit in BUMP_UP and rearm in BUMP_DOWN are ignored
        step(100, 100, 1'b0, '0, 4'b0001, "rearm_used");
        check("rearm_used idle", 32'(used[0]), 32'd0);
        step(100, 100, 1'b0, 4'b0001, '0, "rehit");
        step(100, 100, 1'b1, '0, '0, "t1");
        step(100, 100, 1'b1, '0, '0, "t2");
        step(100, 100, 1'b0, 4'b0001, '0, "hit_in_up");
        step(100, 100, 1'b1, '0, '0, "t3");
        step(100, 100, 1'b1, '0, '0, "t4");
        step(100, 100, 1'b0, '0, 4'b0001, "rearm_in_down");
        for (int t = 5; t <= 2*BP; t++) begin
            step(100, 100, 1'b1, '0, '0, "t_down");
            check("t_down used", 32'(used[0]), (t == 2*BP) ? 32'd1 : 32'd0);
        end
        step(100, 100, 1'b0, '0, 4'b0001, "rearm_again");
        check("rearm_again idle", 32'(used[0]), 32'd0);

        // overlapping boxes: box0 USED wins over idle box1
        bx[1] = 100; by[1] = 100;
        step(100, 100, 1'b0, 4'b0001, '0, "ovl_hit");
        for (int t = 1; t <= 2*BP; t++) step(100, 100, 1'b1, '0, '0, "ovl_tick");
        step(100, 100, 1'b0, '0, '0, "ovl_pix");
        check("overlap box0 wins", {8'h00, color}, {8'h00, BROWN_DARK});
        step(100, 100, 1'b0, '0, 4'b0001, "ovl_rearm");
        bx[1] = 300; by[1] = 60;

        // reset in the middle of a bump, with a hit pending during reset
        step(100, 100, 1'b0, 4'b0001, '0, "rst_hit");
        for (int t = 1; t <= 3; t++) step(100, 100, 1'b1, '0, '0, "rst_tick");
        step(100, 100 - 3 - 16, 1'b0, '0, '0, "rst_pre");
        #2;
        reset = 1'b1;
        hit   = 4'b0001;
        #1;
        check("async reset enable", 32'(enable), 32'd0);
        check("async reset color",  {8'h00, color}, {8'h00, BLACK});
        check("async reset used",   32'(used), 32'd0);
        @(negedge clk);
        hit = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(100, 84, 1'b0, '0, '0, "post_rst_top");
        check("post_rst offset0", {8'h00, color}, {8'h00, BROWN});
        step(100, 100, 1'b1, '0, '0, "post_rst_tick");
        step(100, 83, 1'b0, '0, '0, "post_rst_nohit");
        check("post_rst no bump", 32'(enable), 32'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int j, px, py;
            logic tk;
            logic [NB-1:0] h, r;
            if (n % 50 == 0) begin
                for (int i = 0; i < NB; i++) begin
                    bx[i] = int'($urandom_range(0, 1023));
                    by[i] = int'($urandom_range(0, 1023));
                end
                bx[1] = bx[0] + int'($urandom_range(0, 20));
                by[1] = by[0] + int'($urandom_range(0, 20));
                if (bx[1] > 1023) bx[1] = 1023;
                if (by[1] > 1023) by[1] = 1023;
            end
            j  = int'($urandom_range(0, NB - 1));
            px = bx[j] + int'($urandom_range(0, 48)) - 24;
            py = by[j] + int'($urandom_range(0, 60)) - 30;
            if (px < 0) px = 0;
            if (px > 1023) px = 1023;
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            tk = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NB; i++) begin
                h[i] = ($urandom_range(0, 19) == 0);
                r[i] = ($urandom_range(0, 3) == 0);
            end
            step(px, py, tk, h, r, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
